// File: rtl/motion_pkg.sv
// Shared types and helpers for the motion magnitude datapath.
// Holds the handshake FSM states, rounding modes and the abs helper.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_NEAREST = 1;

  // Magnitude of a w-bit two's-complement value held in the low bits of v.
  // The most negative value maps to 2^(w-1), so the result needs w bits.
  function automatic logic [31:0] abs_u(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] one;
    one = 32'd1;
    if (v[w-1])
      return (one << w) - v;
    else
      return v;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial restoring integer square root, one root bit per cycle.
// Ports: start/rad in, root/exact out, done pulse after the last bit.
import motion_pkg::*;

module isqrt_seq #(
  parameter int W     = 9,
  parameter int ROUND = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] rad,
  output logic [W-1:0]   root,
  output logic           exact,
  output logic           done
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] s_sh;
  logic [W-1:0]   q;
  logic [W+1:0]   r;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic           done_r;

  logic [W+3:0]   r_sh;
  logic [W+3:0]   trial;
  logic           ge;
  logic [W+1:0]   r_nx;
  logic           up;

  // Bring down the next radicand pair and try to set the next root bit.
  assign r_sh  = {r, s_sh[2*W-1 -: 2]};
  assign trial = {2'b00, q, 2'b01};
  assign ge    = r_sh >= trial;
  assign r_nx  = ge ? (W+2)'(r_sh - trial)
                    : (W+2)'(r_sh);

  // sqrt(S) >= q + 1/2  <=>  S - q^2 > q for integers.
  assign up    = (ROUND == ROUND_NEAREST) &&
                 (r > {2'b00, q});
  assign root  = q + {{(W-1){1'b0}}, up};
  assign exact = (r == '0);
  assign done  = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sh   <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        s_sh <= rad;
        q    <= '0;
        r    <= '0;
        cnt  <= CW'(W-1);
        busy <= 1'b1;
      end else if (busy) begin
        s_sh <= s_sh << 2;
        q    <= {q[W-2:0], ge};
        r    <= r_nx;
        if (cnt == '0) begin
          busy   <= 1'b0;
          done_r <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/motion_magnitude.sv
// Magnitude sqrt(dx^2+dy^2) of a signed mouse delta, valid/ready in and out.
// Ports: in_valid/in_ready/dx/dy in, out_valid/out_ready/out_mag/out_exact out.
import motion_pkg::*;

module motion_magnitude #(
  parameter int W     = 9,
  parameter int ROUND = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dx,
  input  logic [W-1:0] dy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_mag,
  output logic         out_exact
);

  state_t         state;
  logic [W-1:0]   ax;
  logic [W-1:0]   ay;
  logic [2*W-1:0] sq;
  logic           start;
  logic [W-1:0]   root;
  logic           exact;
  logic           done;

  // Max is 2 * 2^(2W-2) = 2^(2W-1), so 2W bits never overflow.
  assign sq = ({{W{1'b0}}, ax} * {{W{1'b0}}, ax})
            + ({{W{1'b0}}, ay} * {{W{1'b0}}, ay});

  assign start = (state == SQUARE);

  isqrt_seq #(
    .W     (W),
    .ROUND (ROUND)
  ) u_isqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rad   (sq),
    .root  (root),
    .exact (exact),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_exact <= 1'b0;
      ax        <= '0;
      ay        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ax       <= W'(abs_u(32'(dx), W));
            ay       <= W'(abs_u(32'(dy), W));
            in_ready <= 1'b0;
            state    <= SQUARE;
          end
        end
        SQUARE: begin
          state <= ROOT;
        end
        ROOT: begin
          if (done) begin
            out_mag   <= root;
            out_exact <= exact;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_magnitude.sv
// Bench for motion_magnitude: floor and round builds side by side.
// Random deltas and random backpressure against an arithmetic model.
module tb_motion_magnitude;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dx = '0;
  logic [W-1:0] dy = '0;

  logic         in_ready_f, out_valid_f, out_exact_f;
  logic [W-1:0] out_mag_f;
  logic         in_ready_r, out_valid_r, out_exact_r;
  logic [W-1:0] out_mag_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motion_magnitude #(.W(W), .ROUND(0)) u_floor (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_f),
    .dx        (dx),
    .dy        (dy),
    .out_valid (out_valid_f),
    .out_ready (out_ready),
    .out_mag   (out_mag_f),
    .out_exact (out_exact_f)
  );

  motion_magnitude #(.W(W), .ROUND(1)) u_round (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_r),
    .dx        (dx),
    .dy        (dy),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_mag   (out_mag_r),
    .out_exact (out_exact_r)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer search for the largest q with q*q <= S.
  task automatic model(
    input  int sx,
    input  int sy,
    output int fl,
    output int rn,
    output bit ex
  );
    int s;
    int q;
    s = sx * sx + sy * sy;
    q = 0;
    while ((q + 1) * (q + 1) <= s) q++;
    fl = q;
    ex = (q * q == s);
    rn = (s - q * q > q) ? q + 1 : q;
  endtask

  task automatic run(
    input int sx,
    input int sy,
    input int hold
  );
    int fl, rn, lat;
    bit ex, stable;
    logic [W-1:0] m0, m1;
    model(sx, sy, fl, rn, ex);
    lat = 0;
    while (!in_ready_f && lat < 40) begin
      tick();
      lat++;
    end
    check("in_ready_wait", 32'(in_ready_f), 1);
    dx = sx[W-1:0];
    dy = sy[W-1:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_f && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      dx = W'($urandom);
      dy = W'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), W + 2);
    check("valid_round", 32'(out_valid_r), 1);
    check("mag_floor", 32'(out_mag_f), 32'(fl));
    check("mag_round", 32'(out_mag_r), 32'(rn));
    check("exact_floor", 32'(out_exact_f), 32'(ex));
    check("exact_round", 32'(out_exact_r), 32'(ex));
    check("busy_ready", 32'(in_ready_f), 0);
    m0 = out_mag_f;
    m1 = out_mag_r;
    stable = 1'b1;
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      dx = W'($urandom);
      dy = W'($urandom);
      tick();
      if (out_mag_f !== m0 || out_mag_r !== m1 ||
          out_valid_f !== 1'b1 || in_ready_f !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) check("hold_stable", 32'(stable), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_after", 32'(in_ready_f), 1);
    check("valid_drop", 32'(out_valid_f), 0);
  endtask

  initial begin
    #1_000_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int sx, sy;
    bit quiet;
    #12;
    check("rst_ready", 32'(in_ready_f), 1);
    check("rst_valid", 32'(out_valid_f), 0);
    check("rst_mag", 32'(out_mag_f), 0);
    check("rst_exact", 32'(out_exact_f), 0);
    rst_n = 1'b1;
    tick();

    run(3, -4, 0);
    check("mag_3_4", 32'(out_mag_f), 5);
    run(-256, -256, 5);
    check("mag_256r", 32'(out_mag_r), 362);
    run(2, 3, 0);
    check("mag_2_3r", 32'(out_mag_r), 4);
    run(0, 0, 0);
    run(-256, 0, 0);
    run(255, -256, 2);
    run(100, -7, 20);

    // Reset while the root is being built.
    dx = W'(100);
    dy = W'(50);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid_f), 0);
    check("mid_rst_ready", 32'(in_ready_f), 1);
    check("mid_rst_mag", 32'(out_mag_f), 0);
    check("mid_rst_exact", 32'(out_exact_r), 0);
    #3;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (15) begin
      tick();
      if (out_valid_f !== 1'b0 || out_valid_r !== 1'b0)
        quiet = 1'b0;
    end
    check("no_pulse", 32'(quiet), 1);
    run(6, 8, 0);
    check("mag_6_8", 32'(out_mag_f), 10);

    for (int i = 0; i < 1000; i++) begin
      sx = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
      sy = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
      run(sx, sy, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
